control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit bus machine. It owns the T-state step counter and the flags register, and decodes the 4-bit opcode from the instruction register into a 16-bit control word.
- The control word drives every bus module, including the adder/subtractor's `su` and `out` inputs.
- It sits directly downstream of the adder/subtractor: it consumes `ovf`/`zf`, latches them as carry/zero flags, and uses them for conditional jumps.

Parameters:
- STEPS, 5, number of microsteps per instruction. Legal range 5..8. Steps 5..STEPS-1 emit an all-zero control word.
- FLAGS_INIT, 2'b00, reset value of {carry_flag, zero_flag}.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- ir_opcode  input  4  upper nibble of the instruction register
- alu_ovf  input  1  adder/subtractor carry/borrow out (result bit 8)
- alu_zf  input  1  adder/subtractor zero indication
- ctrl_word  output  16  control word; bit map below
- step  output  3  current microstep
- carry_flag  output  1  latched carry
- zero_flag  output  1  latched zero
- halted  output  1  machine halted

Behaviour:
- ctrl_word bit map, MSB to LSB:
  - 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO
  - 7 EO (drives adder `out`), 6 SU (drives adder `su`), 5 BI, 4 OI
  - 3 CE, 2 CO, 1 J, 0 FI
- Reset (rst_n low, asynchronous):
  - step=0, halted=0, {carry_flag, zero_flag}=FLAGS_INIT.
  - ctrl_word is forced to 16'h0000 for as long as rst_n is low.
- ctrl_word is combinational from (step, ir_opcode, flags, halted). It has zero-cycle latency, i.e. it is valid for the whole cycle that follows a step change.
- Step counter:
  - Increments on each rising edge while halted=0.
  - Wraps from STEPS-1 to 0.
  - Holds its value while halted=1.
- Fetch, independent of opcode:
  - Step 0 = MI|CO = 16'h4004.
  - Step 1 = RO|II|CE = 16'h1408.
- Execute, steps 2..4:
  - LDA 0001: s2 IO|MI = 16'h4800; s3 RO|AI = 16'h1200; s4 0.
  - ADD 0010: s2 IO|MI; s3 RO|BI = 16'h1020; s4 EO|AI|FI = 16'h0281.
  - SUB 0011: s2 IO|MI; s3 RO|BI; s4 EO|AI|SU|FI = 16'h02C1. SU is asserted only in this step.
  - STA 0100: s2 IO|MI; s3 AO|RI = 16'h2100; s4 0.
  - LDI 0101: s2 IO|AI = 16'h0A00.
  - JMP 0110: s2 IO|J = 16'h0802.
  - JC 0111: s2 IO|J if carry_flag=1, else 16'h0000.
  - JZ 1000: s2 IO|J if zero_flag=1, else 16'h0000.
  - OUT 1110: s2 AO|OI = 16'h0110.
  - HLT 1111: s2 HLT = 16'h8000.
  - All other opcodes (0000, 1001–1101): 16'h0000 in steps 2..STEPS-1.
- Flags:
  - On a rising edge where ctrl_word[0] (FI) = 1: carry_flag<=alu_ovf, zero_flag<=alu_zf.
  - Otherwise the flags hold their value.
  - X/Z on the ALU inputs when FI=0 must not disturb the flags.
- Halt:
  - The rising edge with step=2 and ir_opcode=1111 sets halted=1, and step stays at 2.
  - While halted, ctrl_word holds 16'h8000 and the flags freeze.
  - Only rst_n exits the halt state.
- The flags are read for JC/JZ at step 2 using their registered values. An FI in the same instruction cannot occur, because FI is asserted only at step 4.
- Reset mid-instruction aborts the instruction immediately. Execution restarts at step 0 after rst_n rises.
- ir_opcode changing during steps 0–1 has no effect on ctrl_word.

Test Plan:
- Reset release, ir_opcode=0000:
  - Required: ctrl_word reads 0000 while reset, then 4004, 1408, 0000, 0000, 0000, 4004 on successive cycles.
  - Required: step sequence 0,1,2,3,4,0.
- ADD with alu_ovf=1, alu_zf=1 held during step 4:
  - Required: ctrl_word=0281 at step 4.
  - Required: carry_flag=1 and zero_flag=1 after that edge.
  - Required: the flags are unchanged at the other steps even when alu_ovf/alu_zf toggle.
- SUB with alu_ovf=0, alu_zf=0:
  - Required: step 4 ctrl_word=02C1.
  - Required: SU=0 in every other step.
  - Required: the flags clear to 0.
- JC after carry=1, then JC after carry=0; JZ after zero=1:
  - Required: step 2 = 0802, 0000 and 0802 respectively.
- HLT:
  - Required: ctrl_word=8000 at step 2, halted=1 after the edge, step frozen at 2 for 10 cycles.
  - Then pulse rst_n low mid-cycle. Required: immediate ctrl_word=0000, step=0, halted=0, and fetch resumes with 4004.
- STEPS=6, ir_opcode=0101:
  - Required: sequence 4004, 1408, 0A00, 0000, 0000, 0000, then wrap to 4004.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit bus machine.
// Owns the T-state counter, the carry/zero flags and the halt latch, and
// decodes (step, opcode, flags) into the 16-bit bus control word.
module control_sequencer #(
    parameter int         STEPS      = 5,      // microsteps per instruction, 5..8
    parameter logic [1:0] FLAGS_INIT = 2'b00   // reset value of {carry, zero}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ir_opcode,
    input  logic        alu_ovf,
    input  logic        alu_zf,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        halted
);

    // Control word bit positions, MSB to LSB
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [2:0]  step_reg;
    logic [2:0]  step_next;
    logic        halted_reg;
    logic        carry_reg;
    logic        zero_reg;
    logic [15:0] word_next;

    // Next microstep: wrap after the last step of the instruction
    always_comb begin
        step_next = (step_reg == LAST_STEP) ? 3'd0 : step_reg + 3'd1;
    end

    // Microcode decode; steps beyond 4 and unknown opcodes emit nothing
    always_comb begin
        word_next = 16'h0000;
        if (halted_reg) begin
            word_next = HLT;
        end else begin
            case (step_reg)
                3'd0: word_next = MI | CO;
                3'd1: word_next = RO | II | CE;
                3'd2: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: word_next = IO | MI;
                        OP_LDI: word_next = IO | AI;
                        OP_JMP: word_next = IO | J;
                        OP_JC:  word_next = carry_reg ? (IO | J) : 16'h0000;
                        OP_JZ:  word_next = zero_reg  ? (IO | J) : 16'h0000;
                        OP_OUT: word_next = AO | OI;
                        OP_HLT: word_next = HLT;
                        default: word_next = 16'h0000;
                    endcase
                end
                3'd3: begin
                    case (ir_opcode)
                        OP_LDA:         word_next = RO | AI;
                        OP_ADD, OP_SUB: word_next = RO | BI;
                        OP_STA:         word_next = AO | RI;
                        default:        word_next = 16'h0000;
                    endcase
                end
                3'd4: begin
                    case (ir_opcode)
                        OP_ADD:  word_next = EO | AI | FI;
                        OP_SUB:  word_next = EO | AI | SU | FI;
                        default: word_next = 16'h0000;
                    endcase
                end
                default: word_next = 16'h0000;
            endcase
        end
    end

    // Bus sees an idle control word for as long as reset is held
    always_comb begin
        ctrl_word = rst_n ? word_next : 16'h0000;
    end

    // Step counter, halt latch and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_reg   <= 3'd0;
            halted_reg <= 1'b0;
            carry_reg  <= FLAGS_INIT[1];
            zero_reg   <= FLAGS_INIT[0];
        end else begin
            if (!halted_reg) begin
                // HLT freezes the counter at step 2 rather than advancing
                if (step_reg == 3'd2 && ir_opcode == OP_HLT) begin
                    halted_reg <= 1'b1;
                end else begin
                    step_reg <= step_next;
                end
            end
            // ALU inputs are only looked at when FI is asserted
            if (word_next[0]) begin
                carry_reg <= alu_ovf;
                zero_reg  <= alu_zf;
            end
        end
    end

    assign step       = step_reg;
    assign halted     = halted_reg;
    assign carry_flag = carry_reg;
    assign zero_flag  = zero_reg;

endmodule
